back_substitution_detector: RTL and testbench

//  Consumes the triangularised system (upper-triangular R, rotated z = Q^T*y) from the Givens QR stage.

---
 rtl/back_substitution_detector.sv | 137 +++++++++++++
 tb/tb_back_substitution_detector.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/back_substitution_detector.sv
// Back-substitution MIMO detector with a per-row PAM-4 slicer.
// One shared shift-add MAC walks the upper-triangular R row by row.
module back_substitution_detector #(
  parameter int N     = 8,
  parameter int WL    = 16,
  parameter int ACC_W = WL + $clog2(N) + 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WL*N*N-1:0] Rmatrix_i,
  input  logic [WL*N-1:0]   Zarray_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic [3*N-1:0]    x_o,
  output logic              valid_o,
  input  logic              ready_i
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = WL + 2;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    SLICE,
    DONE
  } state_t;

  state_t state, state_nx;

  logic signed [WL-1:0]    rm [N][N];
  logic signed [WL-1:0]    zv [N];
  logic signed [2:0]       xr [N];
  logic signed [ACC_W-1:0] acc;
  logic [IW-1:0]           row;
  logic [IW-1:0]           col;

  logic signed [WL-1:0]    r_mac;
  logic signed [WL-1:0]    r_dg;
  logic signed [2:0]       x_mac;
  logic signed [PW-1:0]    r_e;
  logic signed [PW-1:0]    r_3;
  logic signed [PW-1:0]    p_mag;
  logic signed [PW-1:0]    prod;
  logic signed [ACC_W-1:0] dg;
  logic signed [ACC_W-1:0] a_p;
  logic signed [ACC_W-1:0] r_p;
  logic signed [ACC_W-1:0] r_2;
  logic [2:0]              dec;

  assign ready_o = (state == IDLE);
  assign valid_o = (state == DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (valid_i) state_nx = SLICE;
      MAC:     if (col == IW'(N-1)) state_nx = SLICE;
      SLICE:   state_nx = (row == '0) ? DONE : MAC;
      DONE:    if (ready_i) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // x is always +-1 or +-3, so R*x is R or 3R, optionally negated
  always_comb begin
    r_mac = rm[row][col];
    x_mac = xr[col];
    r_e   = PW'(r_mac);
    r_3   = (r_e <<< 1) + r_e;
    p_mag = (x_mac[2] ^ x_mac[1]) ? r_3 : r_e;
    prod  = x_mac[2] ? -p_mag : p_mag;
  end

  always_comb begin
    r_dg = rm[row][row];
    dg   = ACC_W'(r_dg);
    a_p  = dg[ACC_W-1] ? -acc : acc;
    r_p  = dg[ACC_W-1] ? -dg : dg;
    r_2  = r_p <<< 1;
    if (a_p < -r_2)        dec = 3'b101;
    else if (a_p[ACC_W-1]) dec = 3'b111;
    else if (a_p < r_2)    dec = 3'b001;
    else                   dec = 3'b011;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
      row <= '0;
      col <= '0;
      for (int i = 0; i < N; i++) begin
        zv[i] <= '0;
        xr[i] <= '0;
        for (int j = 0; j < N; j++) rm[i][j] <= '0;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (valid_i) begin
            for (int i = 0; i < N; i++) begin
              zv[i] <= Zarray_i[i*WL +: WL];
              for (int j = 0; j < N; j++)
                rm[i][j] <= Rmatrix_i[(i*N+j)*WL +: WL];
            end
            row <= IW'(N-1);
            acc <= ACC_W'(signed'(Zarray_i[(N-1)*WL +: WL]));
          end
        end
        MAC: begin
          acc <= acc - ACC_W'(prod);
          col <= col + 1'b1;
        end
        SLICE: begin
          xr[row] <= dec;
          if (row != '0) begin
            row <= row - 1'b1;
            col <= row;
            acc <= ACC_W'(zv[row - 1'b1]);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    x_o = '0;
    for (int i = 0; i < N; i++) x_o[3*i +: 3] = xr[i];
  end

endmodule

// File: tb/tb_back_substitution_detector.sv
// Scoreboard bench for back_substitution_detector.
// Drives an N=8 and an N=2 instance with directed vectors.
module tb_back_substitution_detector;

  localparam int WL = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [WL*64-1:0] rm8;
  logic [WL*8-1:0]  z8;
  logic             vi8, ro8, vo8, ri8;
  logic [23:0]      x8;

  logic [WL*4-1:0]  rm2;
  logic [WL*2-1:0]  z2;
  logic             vi2, ro2, vo2, ri2;
  logic [5:0]       x2;

  back_substitution_detector #(.N(8), .WL(WL)) dut8 (
    .clk(clk), .rst(rst), .Rmatrix_i(rm8), .Zarray_i(z8),
    .valid_i(vi8), .ready_o(ro8), .x_o(x8), .valid_o(vo8),
    .ready_i(ri8)
  );

  back_substitution_detector #(.N(2), .WL(WL)) dut2 (
    .clk(clk), .rst(rst), .Rmatrix_i(rm2), .Zarray_i(z2),
    .valid_i(vi2), .ready_o(ro2), .x_o(x2), .valid_o(vo2),
    .ready_i(ri2)
  );

  typedef struct {
    logic [23:0] x;
    int          lat;
  } exp_t;

  exp_t q8[$], q2[$], e8, e2;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int cap8 = 0;
  int cap2 = 0;
  logic pv8 = 1'b0;
  logic pv2 = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst && vi8 && ro8) cap8 <= cyc + 1;
    if (rst && vi2 && ro2) cap2 <= cyc + 1;
  end

  always @(negedge clk) begin
    if (vo8 && !pv8) begin
      if (q8.size() == 0) chk("spurious_valid8", vo8, 0);
      else begin
        e8 = q8.pop_front();
        chk("x8", x8, e8.x);
        chk("lat8", cyc - cap8, e8.lat);
      end
    end
    pv8 = vo8;
  end

  always @(negedge clk) begin
    if (vo2 && !pv2) begin
      if (q2.size() == 0) chk("spurious_valid2", vo2, 0);
      else begin
        e2 = q2.pop_front();
        chk("x2", x2, e2.x[5:0]);
        chk("lat2", cyc - cap2, e2.lat);
      end
    end
    pv2 = vo2;
  end

  function automatic logic [2:0] enc(input int v);
    return 3'(v);
  endfunction

  function automatic logic [23:0] pack8(input int s[8]);
    logic [23:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) p[3*i +: 3] = enc(s[i]);
    return p;
  endfunction

  function automatic logic [WL*64-1:0] mk_r(input int d[8],
                                            input int off,
                                            input int low);
    logic [WL*64-1:0] r;
    int v;
    r = '0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        v = (j > i) ? off : ((j == i) ? d[i] : low);
        r[(i*8+j)*WL +: WL] = WL'(v);
      end
    return r;
  endfunction

  function automatic logic [WL*8-1:0] mk_z(input int d[8], input int off,
                                           input int s[8], input int nz);
    logic [WL*8-1:0] z;
    int v;
    z = '0;
    for (int k = 0; k < 8; k++) begin
      v = d[k] * s[k] + ((k % 2 == 1) ? nz : -nz);
      for (int c = k + 1; c < 8; c++) v += off * s[c];
      z[k*WL +: WL] = WL'(v);
    end
    return z;
  endfunction

  task automatic send8(input logic [WL*64-1:0] r, input logic [WL*8-1:0] z,
                       input logic [23:0] x, input int lat);
    int n = 0;
    q8.push_back('{x: x, lat: lat});
    rm8 = r;
    z8  = z;
    vi8 = 1'b1;
    while (!ro8 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("cap8_ready", ro8, 1);
    @(negedge clk);
    vi8 = 1'b0;
    rm8 = '1;
    z8  = '1;
  endtask

  task automatic drain8();
    int n = 0;
    while ((q8.size() != 0 || !ro8) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain8", q8.size(), 0);
  endtask

  task automatic send2(input int r00, r01, r11, z0, z1, x0, x1);
    int n = 0;
    q2.push_back('{x: {18'd0, enc(x1), enc(x0)}, lat: 3});
    rm2 = {WL'(r11), WL'(-99), WL'(r01), WL'(r00)};
    z2  = {WL'(z1), WL'(z0)};
    vi2 = 1'b1;
    while (!ro2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("cap2_ready", ro2, 1);
    @(negedge clk);
    vi2 = 1'b0;
    rm2 = '1;
    z2  = '1;
  endtask

  task automatic drain2();
    int n = 0;
    while ((q2.size() != 0 || !ro2) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain2", q2.size(), 0);
  endtask

  initial begin
    int d[8];
    int s[8];
    int n;
    int seen;
    int cap_a;
    logic [23:0]     xe;
    logic [WL*8-1:0] zz;

    rst = 1'b1;
    vi8 = 1'b0; vi2 = 1'b0;
    ri8 = 1'b1; ri2 = 1'b1;
    rm8 = '0; z8 = '0; rm2 = '0; z2 = '0;
    #2 rst = 1'b0;
    #6;
    chk("rst_valid8", vo8, 0);
    chk("rst_x8", x8, 0);
    chk("rst_valid2", vo2, 0);
    chk("rst_x2", x2, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_ready8", ro8, 1);
    chk("rst_ready2", ro2, 1);

    d = '{default: 256};
    s = '{3, -1, 1, -3, 3, 1, -1, -3};
    send8(mk_r(d, 0, 0), mk_z(d, 0, s, 0), pack8(s), 36);
    drain8();

    s = '{-3, 3, -1, 1, 1, -3, 3, -1};
    send8(mk_r(d, 64, 999), mk_z(d, 64, s, 30), pack8(s), 36);
    drain8();

    d = '{256, -256, 256, -256, 256, -256, 256, -256};
    s = '{1, 1, -3, 3, -1, -3, 3, -1};
    send8(mk_r(d, -48, -7), mk_z(d, -48, s, 0), pack8(s), 36);
    drain8();

    send2(256, 128, 256, 640, 768, 1, 3);
    drain2();
    send2(256, 0, -256, 256, -768, 1, 3);
    drain2();
    send2(256, 0, 256, -768, 512, -3, 3);
    drain2();
    send2(256, 0, 256, -256, 0, -1, 1);
    drain2();
    send2(256, 0, 256, 512, -512, 3, -1);
    drain2();
    send2(256, 100, 256, -300, -768, 1, -3);
    drain2();
    send2(-256, 100, 256, -200, 768, 1, 3);
    drain2();

    d = '{default: 256};
    s = '{1, 3, -3, -1, 1, 3, -3, -1};
    xe = pack8(s);
    ri8 = 1'b0;
    send8(mk_r(d, 0, 0), mk_z(d, 0, s, 0), xe, 36);
    n = 0;
    while (!vo8 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid_seen", vo8, 1);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        vi8 = 1'b1;
        rm8 = mk_r(d, 0, 0);
        z8  = '0;
      end else vi8 = 1'b0;
      @(negedge clk);
      chk("bp_valid", vo8, 1);
      chk("bp_x", x8, xe);
      chk("bp_ready", ro8, 0);
    end
    ri8 = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", ro8, 1);
    chk("bp_release_valid", vo8, 0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (vo8 || !ro8) seen++;
    end
    chk("bp_no_capture", seen, 0);

    s = '{3, -1, 1, -3, 3, 1, -1, -3};
    send8(mk_r(d, 0, 0), mk_z(d, 0, s, 0), pack8(s), 36);
    repeat (9) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    chk("mid_rst_valid", vo8, 0);
    chk("mid_rst_x", x8, 0);
    q8.delete();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    s = '{-1, -3, 3, 1, -1, 3, 1, -3};
    send8(mk_r(d, 64, 5), mk_z(d, 64, s, -40), pack8(s), 36);
    drain8();

    d = '{256, 256, 256, 0, 256, 256, 256, 256};
    s = '{3, -1, 1, -3, 3, 1, -1, -3};
    zz = mk_z(d, 0, s, 0);
    zz[3*WL +: WL] = WL'(-5);
    send8(mk_r(d, 0, 0), zz, pack8(s), 36);
    cap_a = cap8;
    s[3] = 3;
    zz[3*WL +: WL] = '0;
    send8(mk_r(d, 0, 0), zz, pack8(s), 36);
    chk("b2b_gap", cap8 - cap_a, 38);
    drain8();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
